subtractor_serial_32bit: RTL and testbench

Multi-cycle, slice-serial unsigned/two's-complement subtractor computing `A_i - B_i - bin_i` one `SLICE`-bit slice per clock. It is the inverse-direction companion to the ripple-carry adder family in the ASIC adder-comparison flow. It trades latency for area: one ripple slice is reused `NUM_SLICES` times. A valid/ready handshake frames each operation on both the input and output sides.

---
 rtl/subtractor_serial_32bit_pkg.sv | 18 +
 rtl/subtractor_serial_32bit_if.sv | 46 ++++
 rtl/subtractor_serial_32bit_slice.sv | 28 ++
 rtl/subtractor_serial_32bit.sv | 112 +++++++++++
 tb/tb_subtractor_serial_32bit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/subtractor_serial_32bit_pkg.sv
// Shared types and default sizing for the slice-serial subtractor.
// Imported by the interface, the slice and the top level.
package subtractor_pkg;

  localparam int SUB_WIDTH = 32;
  localparam int SUB_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/subtractor_serial_32bit_if.sv
// Operand/result bundle with valid/ready handshakes on both sides.
// master = requester/consumer, slave = the subtractor.
interface subtractor_serial_32bit_if
  import subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) ();

  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             bin_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] DIFF_o;
  logic             bout_o;
  logic             ovf_o;
  logic             valid_o;
  logic             ready_i;

  modport master (
    output A_i,
    output B_i,
    output bin_i,
    output valid_i,
    output ready_i,
    input  ready_o,
    input  DIFF_o,
    input  bout_o,
    input  ovf_o,
    input  valid_o
  );

  modport slave (
    input  A_i,
    input  B_i,
    input  bin_i,
    input  valid_i,
    input  ready_i,
    output ready_o,
    output DIFF_o,
    output bout_o,
    output ovf_o,
    output valid_o
  );

endinterface

// File: rtl/subtractor_serial_32bit_slice.sv
// Combinational ripple slice computing a + ~b + cin.
// Reused once per clock by the serial top level.
module subtractor_8bit_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0]   c;
  logic [SLICE-1:0] nb;

  assign nb   = ~b;
  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign sum[i]  = a[i] ^ nb[i] ^ c[i];
    assign c[i+1]  = (a[i] & nb[i])
                   | (a[i] & c[i])
                   | (nb[i] & c[i]);
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/subtractor_serial_32bit.sv
// Slice-serial subtractor: A - B - bin, SLICE bits per clock.
// Internal carry is the inverted borrow; bout = ~final carry.
module subtractor_serial_32bit
  import subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int SLICE = SUB_SLICE
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  subtractor_serial_32bit_if.slave  bus
);

  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int CNT_W      = cnt_bits(NUM_SLICES);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NUM_SLICES - 1);

  sub_state_e       state_q;
  sub_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             accept;
  logic             last;
  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_sum;
  logic             sl_cout;

  assign accept = (state_q == IDLE) && bus.valid_i;
  assign last   = (state_q == CALC) && (cnt_q == LAST);

  assign sl_a = a_q[int'(cnt_q)*SLICE +: SLICE];
  assign sl_b = b_q[int'(cnt_q)*SLICE +: SLICE];

  subtractor_8bit_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (c_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_comb begin
    res_d = res_q;
    res_d[int'(cnt_q)*SLICE +: SLICE] = sl_sum;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (bus.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      res_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.A_i;
      b_q   <= bus.B_i;
      c_q   <= ~bus.bin_i;
      cnt_q <= '0;
    end else if (state_q == CALC) begin
      res_q <= res_d;
      c_q   <= sl_cout;
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (last) begin
        diff_q <= res_d;
        bout_q <= ~sl_cout;
        // overflow only when operand signs differ
        ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1])
               && (res_d[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.DIFF_o  = diff_q;
  assign bus.bout_o  = bout_q;
  assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_subtractor_serial_32bit.sv
// Directed bench for subtractor_serial_32bit.
// Inputs driven and outputs sampled on the falling edge.
module tb_subtractor_serial_32bit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  subtractor_serial_32bit_if #(.WIDTH(32)) bus ();

  subtractor_serial_32bit #(
    .WIDTH (32),
    .SLICE (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
    output int          edges
  );
    @(negedge clk);
    bus.A_i     = a;
    bus.B_i     = b;
    bus.bin_i   = bin;
    bus.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    edges = 0;
    while (!bus.valid_o && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    bus.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.A_i = '0; bus.B_i = '0; bus.bin_i = 1'b0;
    bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_bad++;
      $display("FAIL rst_ready got %b want 1", bus.ready_o); end
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++;
      $display("FAIL rst_valid got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.DIFF_o !== 32'h0) begin n_bad++;
      $display("FAIL rst_diff got %h want 0", bus.DIFF_o); end
    n_cmp++; if ({bus.bout_o, bus.ovf_o} !== 2'b00) begin n_bad++;
      $display("FAIL rst_flags got %b%b want 00", bus.bout_o, bus.ovf_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e;
    bus.ready_i = 1'b1;
    run_op(32'h0000_000A, 32'h0000_0003, 1'b0, e);
    n_cmp++; if (e !== 4) begin n_bad++;
      $display("FAIL basic_latency got %0d want 4", e); end
    n_cmp++; if (bus.ready_o !== 1'b0) begin n_bad++;
      $display("FAIL basic_rdy_in_done got %b want 0", bus.ready_o); end
    n_cmp++; if (bus.DIFF_o !== 32'h0000_0007) begin n_bad++;
      $display("FAIL basic_diff got %h want 00000007", bus.DIFF_o); end
    n_cmp++; if ({bus.bout_o, bus.ovf_o} !== 2'b00) begin n_bad++;
      $display("FAIL basic_flags got %b%b want 00", bus.bout_o, bus.ovf_o); end
    consume();
    n_cmp++; if ({bus.valid_o, bus.ready_o} !== 2'b01) begin n_bad++;
      $display("FAIL basic_release got v%b r%b want v0 r1",
               bus.valid_o, bus.ready_o); end
  endtask

  task automatic test_borrow();
    int e;
    run_op(32'h0, 32'h1, 1'b0, e);
    n_cmp++; if ({bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o}
                 !== {1'b1, 32'hFFFF_FFFF, 2'b10}) begin n_bad++;
      $display("FAIL borrow0 got v%b %h b%b o%b want v1 ffffffff b1 o0",
               bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o); end
    consume();
    run_op(32'h0, 32'h1, 1'b1, e);
    n_cmp++; if ({bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o}
                 !== {1'b1, 32'hFFFF_FFFE, 2'b10}) begin n_bad++;
      $display("FAIL borrow1 got v%b %h b%b o%b want v1 fffffffe b1 o0",
               bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o); end
    consume();
    run_op(32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1, e);
    n_cmp++; if ({bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o}
                 !== {1'b1, 32'hFFFF_FFFF, 2'b10}) begin n_bad++;
      $display("FAIL equal_bin got v%b %h b%b o%b want v1 ffffffff b1 o0",
               bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o); end
    consume();
  endtask

  task automatic test_overflow();
    int e;
    run_op(32'h8000_0000, 32'h1, 1'b0, e);
    n_cmp++; if ({bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o}
                 !== {1'b1, 32'h7FFF_FFFF, 2'b01}) begin n_bad++;
      $display("FAIL ovf_neg got v%b %h b%b o%b want v1 7fffffff b0 o1",
               bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o); end
    consume();
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, e);
    n_cmp++; if ({bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o}
                 !== {1'b1, 32'h8000_0000, 2'b11}) begin n_bad++;
      $display("FAIL ovf_pos got v%b %h b%b o%b want v1 80000000 b1 o1",
               bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o); end
    consume();
  endtask

  task automatic test_cross_slice();
    int e;
    run_op(32'h0001_0000, 32'h1, 1'b0, e);
    n_cmp++; if ({bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o}
                 !== {1'b1, 32'h0000_FFFF, 2'b00}) begin n_bad++;
      $display("FAIL cross got v%b %h b%b o%b want v1 0000ffff b0 o0",
               bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o); end
    consume();
  endtask

  task automatic test_backpressure();
    int e;
    bus.ready_i = 1'b0;
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, e);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.valid_i = 1'b1;
      bus.A_i = 32'h1;
      bus.B_i = 32'h1;
      n_cmp++; if ({bus.valid_o, bus.ready_o, bus.DIFF_o, bus.bout_o}
                   !== {2'b10, 32'hFFFF_FFF0, 1'b1}) begin n_bad++;
        $display("FAIL bp_hold[%0d] got v%b r%b %h b%b want v1 r0 fffffff0 b1",
                 i, bus.valid_o, bus.ready_o, bus.DIFF_o, bus.bout_o); end
      @(posedge clk);
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
    consume();
    n_cmp++; if ({bus.valid_o, bus.ready_o} !== 2'b01) begin n_bad++;
      $display("FAIL bp_release got v%b r%b want v0 r1",
               bus.valid_o, bus.ready_o); end
    run_op(32'd100, 32'd1, 1'b0, e);
    n_cmp++; if ({e == 4, bus.DIFF_o, bus.bout_o}
                 !== {1'b1, 32'd99, 1'b0}) begin n_bad++;
      $display("FAIL bp_next got edges %0d %h b%b want 4 00000063 b0",
               e, bus.DIFF_o, bus.bout_o); end
    consume();
  endtask

  task automatic test_async_reset();
    int e;
    @(negedge clk);
    bus.A_i = 32'hDEAD_BEEF; bus.B_i = 32'h1;
    bus.bin_i = 1'b0; bus.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.ready_o, bus.valid_o, bus.DIFF_o}
                 !== {2'b10, 32'h0}) begin n_bad++;
      $display("FAIL arst got r%b v%b %h want r1 v0 00000000",
               bus.ready_o, bus.valid_o, bus.DIFF_o); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h1234_5678, 32'h0000_0678, 1'b0, e);
    n_cmp++; if ({bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o}
                 !== {1'b1, 32'h1234_5000, 2'b00}) begin n_bad++;
      $display("FAIL arst_next got v%b %h b%b o%b want v1 12345000 b0 o0",
               bus.valid_o, bus.DIFF_o, bus.bout_o, bus.ovf_o); end
    consume();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_cross_slice();
    test_backpressure();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
